// File: rtl/audio_frame_buffer_ctrl_pkg.sv
// Shared definitions for the audio ping-pong frame buffer controller.
// Reader FSM encodings are fixed because they show up in debug dumps.
package audio_frame_buffer_ctrl_pkg;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_READ  = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/frame_read_seq.sv
// Reader sequencer: walks one frame of read addresses and aligns valid/last
// with the 1-cycle registered memory read.
module frame_read_seq
    import audio_frame_buffer_ctrl_pkg::*;
#(
    parameter int IDX_WIDTH = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic                 pending,
    output logic [IDX_WIDTH-1:0] rd_idx,
    output logic                 draining,
    output logic                 idle_next,
    output logic                 busy,
    output logic                 out_valid,
    output logic                 out_last
);

    localparam logic [IDX_WIDTH-1:0] IDX_LAST = {IDX_WIDTH{1'b1}};
    localparam logic [IDX_WIDTH-1:0] IDX_ZERO = {IDX_WIDTH{1'b0}};
    localparam logic [IDX_WIDTH-1:0] IDX_ONE  = IDX_WIDTH'(1);

    rd_state_e            state_r;
    rd_state_e            state_nxt_s;
    logic [IDX_WIDTH-1:0] rd_idx_r;
    logic                 busy_r;
    logic                 out_valid_r;
    logic                 out_last_r;

    // Reader state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= RD_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; DRAIN is a single cycle that lets the last read word land.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RD_IDLE: begin
                if (frame_start && pending) begin
                    state_nxt_s = RD_READ;
                end else begin
                    state_nxt_s = RD_IDLE;
                end
            end
            RD_READ: begin
                if (rd_idx_r == IDX_LAST) begin
                    state_nxt_s = RD_DRAIN;
                end else begin
                    state_nxt_s = RD_READ;
                end
            end
            RD_DRAIN: state_nxt_s = RD_IDLE;
            default:  state_nxt_s = RD_IDLE;
        endcase
    end

    // Read index and output pipe; the index wraps back to zero on the last address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_idx_r    <= IDX_ZERO;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            if (state_r == RD_READ) begin
                rd_idx_r <= rd_idx_r + IDX_ONE;
            end else begin
                rd_idx_r <= IDX_ZERO;
            end
            busy_r      <= (state_nxt_s != RD_IDLE);
            out_valid_r <= (state_r == RD_READ);
            out_last_r  <= (state_r == RD_READ) && (rd_idx_r == IDX_LAST);
        end
    end

    assign rd_idx    = rd_idx_r;
    assign draining  = (state_r == RD_DRAIN);
    assign idle_next = (state_nxt_s == RD_IDLE);
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;

endmodule

// File: rtl/audio_frame_buffer_ctrl.sv
// Ping-pong frame buffer controller: packs codec samples into alternating
// memory banks and streams each completed frame to the spectrum pipeline.
module audio_frame_buffer_ctrl
    import audio_frame_buffer_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_LENGTH = 14,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_valid,
    input  logic [DATA_WIDTH-1:0]  sample_data,
    output logic                   frame_ready,
    input  logic                   frame_start,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   overrun_cnt,
    output logic                   mem_we,
    output logic [ADDR_LENGTH-1:0] mem_wraddr,
    output logic [DATA_WIDTH-1:0]  mem_wrdata,
    output logic [ADDR_LENGTH-1:0] mem_rdaddr,
    input  logic [DATA_WIDTH-1:0]  mem_rddata
);

    localparam int                   IDX_WIDTH = ADDR_LENGTH - 1;
    localparam logic [IDX_WIDTH-1:0] IDX_LAST  = {IDX_WIDTH{1'b1}};
    localparam logic [IDX_WIDTH-1:0] IDX_ZERO  = {IDX_WIDTH{1'b0}};
    localparam logic [IDX_WIDTH-1:0] IDX_ONE   = IDX_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic [IDX_WIDTH-1:0]   wr_idx_r;
    logic                   wr_bank_r;
    logic                   rd_bank_r;
    logic                   pending_r;
    logic [CNT_WIDTH-1:0]   overrun_cnt_r;
    logic                   mem_we_r;
    logic [ADDR_LENGTH-1:0] mem_wraddr_r;
    logic [DATA_WIDTH-1:0]  mem_wrdata_r;
    logic                   frame_ready_r;

    logic                   frame_done_s;
    logic                   swap_s;
    logic                   overrun_s;
    logic                   pending_nxt_s;
    logic                   draining_s;
    logic                   idle_next_s;
    logic                   rd_out_valid_s;
    logic [IDX_WIDTH-1:0]   rd_idx_s;

    frame_read_seq #(
        .IDX_WIDTH (IDX_WIDTH)
    ) u_read_seq (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .pending     (pending_r),
        .rd_idx      (rd_idx_s),
        .draining    (draining_s),
        .idle_next   (idle_next_s),
        .busy        (busy),
        .out_valid   (rd_out_valid_s),
        .out_last    (out_last)
    );

    // Frame completion arbitration: a bank freed this cycle beats an overrun.
    always_comb begin
        frame_done_s  = sample_valid && (wr_idx_r == IDX_LAST);
        swap_s        = 1'b0;
        overrun_s     = 1'b0;
        pending_nxt_s = pending_r;
        if (frame_done_s) begin
            if (!pending_r || draining_s) begin
                swap_s        = 1'b1;
                pending_nxt_s = 1'b1;
            end else begin
                overrun_s     = 1'b1;
                pending_nxt_s = pending_r;
            end
        end else if (draining_s) begin
            pending_nxt_s = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    // Registered memory write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we_r     <= 1'b0;
            mem_wraddr_r <= {ADDR_LENGTH{1'b0}};
            mem_wrdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            mem_we_r <= sample_valid;
            if (sample_valid) begin
                mem_wraddr_r <= {wr_bank_r, wr_idx_r};
                mem_wrdata_r <= sample_data;
            end
        end
    end

    // Write index, bank ownership, pending flag and overrun counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_idx_r      <= IDX_ZERO;
            wr_bank_r     <= 1'b0;
            rd_bank_r     <= 1'b0;
            pending_r     <= 1'b0;
            overrun_cnt_r <= CNT_ZERO;
            frame_ready_r <= 1'b0;
        end else begin
            if (sample_valid) begin
                wr_idx_r <= wr_idx_r + IDX_ONE;
            end
            if (swap_s) begin
                rd_bank_r <= wr_bank_r;
                wr_bank_r <= ~wr_bank_r;
            end
            if (overrun_s && (overrun_cnt_r != CNT_MAX)) begin
                overrun_cnt_r <= overrun_cnt_r + CNT_ONE;
            end
            pending_r     <= pending_nxt_s;
            frame_ready_r <= pending_nxt_s && idle_next_s;
        end
    end

    assign frame_ready = frame_ready_r;
    assign out_valid   = rd_out_valid_s;
    assign out_data    = rd_out_valid_s ? mem_rddata : {DATA_WIDTH{1'b0}};
    assign overrun_cnt = overrun_cnt_r;
    assign mem_we      = mem_we_r;
    assign mem_wraddr  = mem_wraddr_r;
    assign mem_wrdata  = mem_wrdata_r;
    assign mem_rdaddr  = {rd_bank_r, rd_idx_s};

endmodule
